fetch_queue: RTL and testbench

//  Decoupling FIFO between the instruction fetch unit and the decode stage.
//  - Buffers {pc, instruction} pairs from fetch.
//  - Presents them to decode through a valid/ready handshake.
//  - Discards all buffered entries on a pipeline flush (branch/jump redirect).
//  - Lets fetch keep issuing while decode stalls, until the queue is full.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue_mem.sv | 25 ++
 rtl/fetch_queue.sv | 99 +++++++++
 tb/tb_fetch_queue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-to-decode queue.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    // addi x0,x0,0: presented to decode whenever the queue has nothing valid
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: one synchronous write port, one combinational read port.
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fetch_entry_t             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output fetch_entry_t             rdata
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode with flush support.
// Optional same-cycle fetch-to-decode bypass when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic [XLEN-1:0]            fetch_pc_i,
    input  logic [XLEN-1:0]            fetch_instr_i,
    output logic                       dec_valid_o,
    input  logic                       dec_ready_i,
    output logic [XLEN-1:0]            dec_pc_o,
    output logic [XLEN-1:0]            dec_instr_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic         push;
    logic         pop;
    logic         bypass;
    fetch_entry_t fetch_entry;
    fetch_entry_t head_entry;
    fetch_entry_t out_entry;

    assign fetch_entry = '{pc: fetch_pc_i, instr: fetch_instr_i};

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = (count_q == '0) && fetch_valid_i && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign fetch_ready_o = (count_q != CW'(DEPTH));
    assign dec_valid_o   = (count_q != '0) || bypass;

    // A bypassed entry taken by decode this cycle is never written
    assign push = fetch_valid_i && fetch_ready_o && !flush_i && !(bypass && dec_ready_i);
    assign pop  = (count_q != '0) && dec_ready_i && !flush_i;

    fetch_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (fetch_entry),
        .raddr (rd_ptr_q),
        .rdata (head_entry)
    );

    assign out_entry   = bypass ? fetch_entry : head_entry;
    assign dec_pc_o    = dec_valid_o ? out_entry.pc : '0;
    assign dec_instr_o = dec_valid_o ? out_entry.instr : NOP_INSTR;
    assign count_o     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, XLEN=32).
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_pc_i;
    logic [31:0] fetch_instr_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_instr_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    fetch_queue #(
        .DEPTH (4),
        .XLEN  (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_instr_i (fetch_instr_i),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .dec_pc_o      (dec_pc_o),
        .dec_instr_o   (dec_instr_o),
        .count_o       (count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " valid"}, 32'(dec_valid_o), 32'd0);
        check({tag, " instr"}, dec_instr_o, 32'h0000_0013);
        check({tag, " pc"}, dec_pc_o, 32'd0);
        check({tag, " ready"}, 32'(fetch_ready_o), 32'd1);
        check({tag, " count"}, 32'(count_o), 32'd0);
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA500_0000 ^ pc;
    endfunction

    task automatic push_one(input logic [31:0] pc);
        fetch_valid_i = 1'b1;
        fetch_pc_i    = pc;
        fetch_instr_i = instr_of(pc);
        tick();
        fetch_valid_i = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        dec_ready_i   = 1'b0;
        fetch_pc_i    = '0;
        fetch_instr_i = '0;

        // 1. reset values, idle
        #3;
        check_idle("reset");
        #9 rst_n = 1'b1;
        tick();
        check_idle("idle");

        // 2. fill to DEPTH, reject 5th, drain in order
        for (int i = 0; i < 4; i++) push_one(32'(4 * i));
        check("full count", 32'(count_o), 32'd4);
        check("full ready", 32'(fetch_ready_o), 32'd0);
        check("full head", dec_pc_o, 32'h0);
        push_one(32'h10);
        check("5th rejected count", 32'(count_o), 32'd4);
        dec_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain pc", dec_pc_o, 32'(4 * i));
            check("drain instr", dec_instr_o, instr_of(32'(4 * i)));
            tick();
        end
        dec_ready_i = 1'b0;
        check("drained count", 32'(count_o), 32'd0);
        check("drained valid", 32'(dec_valid_o), 32'd0);
        check("drained instr", dec_instr_o, 32'h0000_0013);

        // 3. streaming push+pop, count holds at 1, pointers wrap
        push_one(32'h0);
        dec_ready_i   = 1'b1;
        fetch_valid_i = 1'b1;
        for (int k = 1; k < 10; k++) begin
            fetch_pc_i    = 32'(4 * k);
            fetch_instr_i = instr_of(32'(4 * k));
            check("stream pc", dec_pc_o, 32'(4 * (k - 1)));
            tick();
            check("stream count", 32'(count_o), 32'd1);
        end
        fetch_valid_i = 1'b0;
        check("stream last", dec_pc_o, 32'h24);
        tick();
        dec_ready_i = 1'b0;
        check("stream empty", 32'(count_o), 32'd0);

        // 4. flush with 3 queued and a same-cycle push
        for (int i = 0; i < 3; i++) push_one(32'h100 + 32'(4 * i));
        check("preflush count", 32'(count_o), 32'd3);
        flush_i       = 1'b1;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h40;
        fetch_instr_i = instr_of(32'h40);
        tick();
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        check("flush count", 32'(count_o), 32'd0);
        check("flush valid", 32'(dec_valid_o), 32'd0);
        tick();
        check("flush no pc40", 32'(count_o), 32'd0);

        // 5. full queue, simultaneous pop and push attempt
        for (int i = 0; i < 4; i++) push_one(32'h200 + 32'(4 * i));
        dec_ready_i   = 1'b1;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h210;
        fetch_instr_i = instr_of(32'h210);
        check("full pop ready", 32'(fetch_ready_o), 32'd0);
        tick();
        check("full pop count", 32'(count_o), 32'd3);
        check("full pop head", dec_pc_o, 32'h204);
        dec_ready_i = 1'b0;
        check("retry ready", 32'(fetch_ready_o), 32'd1);
        tick();
        fetch_valid_i = 1'b0;
        check("retry count", 32'(count_o), 32'd4);
        dec_ready_i = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check("full drain pc", dec_pc_o, 32'h200 + 32'(4 * i));
            tick();
        end
        dec_ready_i = 1'b0;
        check("full drain count", 32'(count_o), 32'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
        // 6. zero-latency bypass on empty queue
        fetch_valid_i = 1'b1;
        dec_ready_i   = 1'b1;
        fetch_pc_i    = 32'd100;
        fetch_instr_i = 32'h0050_0093;
        #1;
        check("bypass valid", 32'(dec_valid_o), 32'd1);
        check("bypass pc", dec_pc_o, 32'd100);
        check("bypass instr", dec_instr_o, 32'h0050_0093);
        tick();
        fetch_valid_i = 1'b0;
        dec_ready_i   = 1'b0;
        check("bypass count", 32'(count_o), 32'd0);
`endif

        // 7. async reset between edges with 2 queued
        push_one(32'h300);
        push_one(32'h304);
        check("prereset count", 32'(count_o), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check_idle("async reset");
        #3 rst_n = 1'b1;
        tick();
        check_idle("post reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
